isqr_squarer: RTL and testbench
===============================

Name: isqr_squarer

Overview:
- Sequential shift-add squarer. Computes square = root*root over WIDTH cycles with a start/done handshake.
- Inverse companion to the digit-recurrence integer square-root datapath in the P2 block.
- The bench also uses it to reconstruct the radicand from a computed root and cross-check the root unit.

Parameters:
- WIDTH, 8, bit width of root operand; square result is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- root_in  input  WIDTH  operand; captured on accepted start
- busy  output  1  high while computing
- done  output  1  one-cycle pulse when square_out becomes valid
- square_out  output  2*WIDTH  result; held until next accepted start
- (SQR_CHECK_EN only) radicand_in  input  2*WIDTH  value the root was computed from; captured with root_in
- (SQR_CHECK_EN only) root_ok  output  1  root consistency flag, valid with done

Behaviour:
- One clock domain; reset is synchronous, active-low, clk/rst_n.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, square_out=0, root_ok=0.
  - Internal multiplicand/multiplier/accumulator/counter cleared.
  - Reset during CALC aborts the operation; no done is produced.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 at edge k -> capture root_in into multiplicand (zero-extended to 2*WIDTH) and multiplier; accumulator=0; counter=0; go CALC.
  - CALC: each cycle:
    - If multiplier[0]=1, add multiplicand to accumulator.
    - Shift multiplicand left 1, shift multiplier right 1, counter+1.
    - After WIDTH CALC cycles (counter reaches WIDTH-1 on the last add), go DONE.
  - DONE: for one cycle, square_out=accumulator and done=1; then go IDLE.
- Timing for accepted start at edge k:
  - busy=1 for cycles k+1..k+WIDTH.
  - done=1 in cycle k+WIDTH+1 only.
  - Fixed latency WIDTH+1; no early termination for zero operands.
- Handshake:
  - start is ignored in CALC and DONE; there is no queueing.
  - start held high continuously restarts on the first IDLE cycle after DONE.
  - done and busy are never high together.
- Arithmetic:
  - Accumulator is 2*WIDTH bits and cannot overflow, since (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - Unsigned only.
- square_out holds its last value through IDLE. It updates only on the DONE entry edge.

Optional Feature:
- Macro SQR_CHECK_EN.
- When defined:
  - radicand_in port exists and is registered with root_in on accept.
  - In DONE, root_ok=1 iff square <= radicand and (radicand - square) <= 2*root, i.e. root = floor(sqrt(radicand)).
  - root_ok is registered, valid only in the done cycle, and 0 otherwise.
  - Comparison uses a 2*WIDTH+1 bit difference to detect negative results.
- When undefined: radicand_in and root_ok ports and all check logic are absent; behaviour otherwise identical.

Decomposition:
- Package isqr_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} sqr_state_t;
  - localparam DEF_WIDTH=8;
  - counter width function clog2-based.
- One sub-module, isqr_sqr_datapath: accumulator, shift registers and adder, with load/step controls from the top-level FSM.
- The check comparator stays in the top level under the macro.

Test Plan:
- Reset then root_in=13, start pulse -> busy cycles 1..8, done at cycle 9, square_out=169 (0x00A9).
- root_in=255 -> square_out=65025 (0xFE01). root_in=0 -> square_out=0, done still at cycle 9.
- start re-asserted with root_in=3 during CALC of root 13 -> ignored; square_out=169. A following start with 3 -> 9.
- rst_n=0 at cycle 4 of CALC -> busy=0, square_out=0, no done. A fresh start with 10 -> 100 at normal latency.
- SQR_CHECK_EN:
  - root=13, radicand=170 -> root_ok=1.
  - radicand=196 -> root_ok=0 (27>26).
  - radicand=168 -> root_ok=0 (square>radicand).
  - root=255, radicand=65535 -> root_ok=1.
- Random 1000 roots with start held high back-to-back -> each done spaced WIDTH+2 cycles; square_out equals root^2.

Source files
------------

// File: rtl/isqr_pkg.sv
// Shared types, defaults and helpers for the shift-add squarer.
package isqr_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} sqr_state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Counter width able to index WIDTH add/shift steps (0..WIDTH-1).
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w <= 1) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/isqr_sqr_datapath.sv
// Shift-add datapath: multiplicand/multiplier shift registers, accumulator and
// step counter. The controlling FSM drives load_i and step_i.
module isqr_sqr_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CntW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     root_i,
  output logic [2*WIDTH-1:0]   acc_next_o,
  output logic [CntW-1:0]      cnt_o
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_add;

  // Conditional add of the current partial product.
  always_comb begin
    acc_add = acc_q;
    if (mplier_q[0]) acc_add = acc_q + mcand_q;
  end

  // Operand capture on load, one shift/add step per cycle on step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, root_i};
      mplier_q <= root_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_add;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end

  // Exposes the post-add value so the final step can be captured directly.
  assign acc_next_o = acc_add;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/isqr_squarer.sv
// Sequential shift-add squarer: square_out = root_in^2 after WIDTH+1 cycles.
// Optional root consistency check enabled by defining SQR_CHECK_EN.
module isqr_squarer
  import isqr_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     root_in,
`ifdef SQR_CHECK_EN
  input  logic [2*WIDTH-1:0]   radicand_in,
  output logic                 root_ok,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   square_out
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  sqr_state_t         state_q, state_d;
  logic               load, step, last_step;
  logic [CntW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] square_q;

  isqr_sqr_datapath #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .root_i     (root_in),
    .acc_next_o (acc_next),
    .cnt_o      (cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CntW'(WIDTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign last_step = step && (cnt == CntW'(WIDTH - 1));

  // Result register; loads only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (!rst_n)         square_q <= '0;
    else if (last_step) square_q <= acc_next;
  end

  assign busy       = (state_q == CALC);
  assign done       = (state_q == DONE);
  assign square_out = square_q;

`ifdef SQR_CHECK_EN
  logic [WIDTH-1:0]   root_q;
  logic [2*WIDTH-1:0] radicand_q;
  logic               root_ok_q;
  logic [2*WIDTH:0]   diff;
  logic [2*WIDTH-1:0] two_root;
  logic               check_pass;

  // Operands for the check, captured alongside the datapath load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      root_q     <= '0;
      radicand_q <= '0;
    end else if (load) begin
      root_q     <= root_in;
      radicand_q <= radicand_in;
    end
  end

  // Extra MSB of diff flags square > radicand.
  always_comb begin
    diff       = {1'b0, radicand_q} - {1'b0, acc_next};
    two_root   = {{(WIDTH - 1){1'b0}}, root_q, 1'b0};
    check_pass = !diff[2*WIDTH] && (diff[2*WIDTH-1:0] <= two_root);
  end

  // Flag is registered with the result, so it is high only in the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) root_ok_q <= 1'b0;
    else        root_ok_q <= last_step && check_pass;
  end

  assign root_ok = root_ok_q;
`endif

endmodule

// File: tb/tb_isqr_squarer.sv
// Directed self-checking bench for isqr_squarer (WIDTH = 8).
module tb_isqr_squarer;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  root_in;
  logic [2*W-1:0] radicand;
  logic          busy;
  logic          done;
  logic [2*W-1:0] square_out;
`ifdef SQR_CHECK_EN
  logic          root_ok;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  isqr_squarer #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .root_in     (root_in),
`ifdef SQR_CHECK_EN
    .radicand_in (radicand),
    .root_ok     (root_ok),
`endif
    .busy        (busy),
    .done        (done),
    .square_out  (square_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Single operation with start pulsed for one cycle; checks the full timeline.
  task automatic run_op(input logic [W-1:0] r, input logic [2*W-1:0] rad,
                        input logic [2*W-1:0] exp_sq, input logic exp_ok, input string tag);
    root_in  = r;
    radicand = rad;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(W); c++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " done_low"}, 32'(done), 32'd0);
`ifdef SQR_CHECK_EN
      check({tag, " ok_low"}, 32'(root_ok), 32'd0);
`endif
      tick();
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    check({tag, " square"}, 32'(square_out), 32'(exp_sq));
`ifdef SQR_CHECK_EN
    check({tag, " root_ok"}, 32'(root_ok), 32'(exp_ok));
`endif
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " hold"}, 32'(square_out), 32'(exp_sq));
  endtask

  logic [W-1:0]   b2b_root[6] = '{8'd1, 8'd2, 8'd7, 8'd16, 8'd100, 8'd200};
  logic [2*W-1:0] b2b_sq[6]   = '{16'd1, 16'd4, 16'd49, 16'd256, 16'd10000, 16'd40000};

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    root_in  = '0;
    radicand = '0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset square", 32'(square_out), 32'd0);
`ifdef SQR_CHECK_EN
    check("reset root_ok", 32'(root_ok), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    run_op(8'd13,  16'd170,   16'h00A9, 1'b1, "r13");
    run_op(8'd255, 16'd65535, 16'hFE01, 1'b1, "r255");
    run_op(8'd0,   16'd0,     16'd0,    1'b1, "r0");
`ifdef SQR_CHECK_EN
    run_op(8'd13, 16'd196, 16'd169, 1'b0, "chk196");
    run_op(8'd13, 16'd168, 16'd169, 1'b0, "chk168");
`endif

    // A second start during CALC must be ignored.
    root_in = 8'd13;
    radicand = 16'd169;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    root_in = 8'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("ign busy", 32'(busy), 32'd1);
    repeat (5) tick();
    check("ign done", 32'(done), 32'd1);
    check("ign square", 32'(square_out), 32'd169);
    tick();
    check("ign idle", 32'(busy), 32'd0);
    run_op(8'd3, 16'd9, 16'd9, 1'b1, "r3");

    // Reset in the 4th CALC cycle aborts the operation.
    root_in = 8'd13;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort square", 32'(square_out), 32'd0);
    for (int c = 0; c < 12; c++) begin
      check("abort no_done", 32'(done), 32'd0);
      tick();
    end
    run_op(8'd10, 16'd100, 16'd100, 1'b1, "r10");

    // Start held high: back-to-back operations spaced W+2 cycles apart.
    start    = 1'b1;
    root_in  = b2b_root[0];
    radicand = b2b_sq[0];
    tick();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < int'(W); c++) begin
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b done_low", 32'(done), 32'd0);
        tick();
      end
      check("b2b done", 32'(done), 32'd1);
      check("b2b square", 32'(square_out), 32'(b2b_sq[i]));
      if (i < 5) begin
        root_in  = b2b_root[i+1];
        radicand = b2b_sq[i+1];
      end else begin
        start = 1'b0;
      end
      tick();
      check("b2b idle_busy", 32'(busy), 32'd0);
      check("b2b idle_done", 32'(done), 32'd0);
      tick();
    end

    // A few random operands against the bench's own arithmetic.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0]   r;
      logic [2*W-1:0] sq;
      r  = W'($urandom_range(0, 255));
      sq = 16'(r) * 16'(r);
      run_op(r, sq, sq, 1'b1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
